shift_r_uint64_pipe: RTL
========================

// Module: shift_r_uint64_pipe
// PURPOSE
//  Pipelined, handshaked front/back end for the combinational shift_r_nbit core (WIDTH=64).
//  Registers operands (stage S1), feeds shift_r_nbit, registers the result (stage S2).
//  Adds full-width shift semantics: if B >= WIDTH, result is forced to 0 (the core alone uses B[5:0]).
//  Keeps a saturating count of out-of-range shifts for PIM benchmark statistics.
// PARAMETERS
//  WIDTH        64  data width of A, B, Y
//  SHIFT_WIDTH  6   shift-amount bits passed to core; WIDTH == 2**SHIFT_WIDTH
//  CNT_WIDTH    16  width of oor_cnt
// PORTS
//  clk        in   1          single clock; all state on rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  in_valid   in   1          operand pair valid
//  in_ready   out  1          block accepts operand pair this cycle
//  in_a       in   WIDTH      value to shift (unsigned)
//  in_b       in   WIDTH      shift amount (unsigned, full width)
//  out_valid  out  1          result valid
//  out_ready  in   1          consumer accepts result this cycle
//  out_y      out  WIDTH      in_a >> in_b (0 when in_b >= WIDTH)
//  out_oor    out  1          result came from an out-of-range shift (in_b >= WIDTH)
//  oor_cnt    out  CNT_WIDTH  number of out-of-range results delivered; saturates at all-ones
// BEHAVIOUR
//  Reset (rst_n low, async): S1/S2 valid=0; out_valid=0, out_y=0, out_oor=0, oor_cnt=0.
//  Datapath regs S1 {a, b_lo[SHIFT_WIDTH-1:0], oor} and S2 {y, oor} need no reset; outputs do.
//  Input accept: in_fire = in_valid & in_ready. On in_fire S1 loads a=in_a, b_lo=in_b[5:0],
//    oor = |in_b[WIDTH-1:SHIFT_WIDTH].
//  Core: shift_r_nbit instance, A=S1.a, B=S1.b_lo; y_next = S1.oor ? 0 : core Y.
//  s2_load = S1.valid & (~out_valid | out_ready); on s2_load: out_y<=y_next, out_oor<=S1.oor, out_valid<=1.
//  out_fire = out_valid & out_ready; if out_fire & ~s2_load: out_valid<=0.
//  S1.valid next = in_fire | (S1.valid & ~s2_load).
//  in_ready = ~S1.valid | s2_load (combinational from out_ready; no skid buffer).
//  Latency: in_fire at cycle t -> out_valid=1 at t+2 when not stalled. Throughput 1/cycle.
//  Back-pressure: out_ready low holds out_y/out_oor stable while out_valid=1; S1 holds; in_ready=0
//    once both stages are full. No data dropped or duplicated; order preserved.
//  Simultaneous out_fire and s2_load: new result replaces old; out_valid stays 1.
//  oor_cnt: +1 on each out_fire with out_oor=1; holds at 2**CNT_WIDTH-1 (no wrap).
//  Boundaries: in_b=0 -> y=in_a; in_b=63 -> y=in_a[63]; in_b=64 or any bit above [5] set -> y=0, oor=1.
//  Reset mid-operation: all in-flight ops discarded, out_valid falls asynchronously; first
//    accept after rst_n rises behaves as from idle.
//  Inputs in_a/in_b are sampled only on in_fire; values while in_ready=0 are ignored.
// TESTING
//  1 A=64'hF000_0000_0000_0000, B=4, out_ready=1 -> 2 cycles later y=64'h0F00_0000_0000_0000, oor=0.
//  2 A=all-ones, B=63 -> y=1; B=64 -> y=0, oor=1, oor_cnt=1; B=64'h100 (low bits 0) -> y=0, oor=1.
//  3 Stream 8 back-to-back ops with out_ready=1 -> one result per cycle, in order, in_ready stays 1.
//  4 Hold out_ready=0 for 5 cycles during stream -> in_ready drops after 2 accepts, out_y stable,
//    no loss/duplication after release.
//  5 Assert rst_n=0 with both stages full -> out_valid=0, oor_cnt=0 immediately; post-reset op correct.
//  6 Preload CNT_WIDTH=2, send 5 out-of-range ops -> oor_cnt stops at 3.

Source files
------------

// File: rtl/shift_r_uint64_pipe_if.sv
// Handshaked operand/result bus for the pipelined right-shift block.
// The master side drives operands and the result ready; the slave is the shifter.
interface shift_r_uint64_pipe_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_oor;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_y, out_oor
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_y, out_oor
    );
endinterface

// File: rtl/shift_r_uint64_pipe.sv
// Two-stage handshaked logical right shift with full-width shift semantics
// and a saturating count of out-of-range results delivered.

// Combinational log-depth barrel shifter; only the low SHIFT_WIDTH bits of b are seen.
module shift_r_nbit #(
    parameter int WIDTH       = 64,
    parameter int SHIFT_WIDTH = 6
) (
    input  logic [WIDTH-1:0]       a,
    input  logic [SHIFT_WIDTH-1:0] b,
    output logic [WIDTH-1:0]       y
);
    logic [WIDTH-1:0] stage [0:SHIFT_WIDTH];

    assign stage[0] = a;

    generate
        for (genvar gi = 0; gi < SHIFT_WIDTH; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign stage[gi+1] = b[gi] ? (stage[gi] >> SH) : stage[gi];
        end
    endgenerate

    assign y = stage[SHIFT_WIDTH];
endmodule

module shift_r_uint64_pipe #(
    parameter int WIDTH       = 64,
    parameter int SHIFT_WIDTH = 6,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_r_uint64_pipe_if.slave bus,
    output logic [CNT_WIDTH-1:0] oor_cnt
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // S1 operand stage
    logic                   s1_valid_reg;
    logic [WIDTH-1:0]       s1_a_reg;
    logic [SHIFT_WIDTH-1:0] s1_b_lo_reg;
    logic                   s1_oor_reg;

    // S2 result stage, which is also the output register
    logic                   out_valid_reg;
    logic [WIDTH-1:0]       out_y_reg;
    logic                   out_oor_reg;
    logic [CNT_WIDTH-1:0]   oor_cnt_reg;

    logic                   in_fire;
    logic                   s2_load;
    logic                   out_fire;
    logic [WIDTH-1:0]       core_y;
    logic [WIDTH-1:0]       y_next;

    // S2 can take a new result when it is empty or being drained this cycle.
    assign s2_load  = s1_valid_reg & (~out_valid_reg | bus.out_ready);
    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = out_valid_reg & bus.out_ready;

    assign bus.in_ready  = ~s1_valid_reg | s2_load;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_y     = out_y_reg;
    assign bus.out_oor   = out_oor_reg;
    assign oor_cnt       = oor_cnt_reg;

    shift_r_nbit #(
        .WIDTH       (WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_core (
        .a (s1_a_reg),
        .b (s1_b_lo_reg),
        .y (core_y)
    );

    // Any set bit above the core's shift field means the whole word shifts out.
    assign y_next = s1_oor_reg ? '0 : core_y;

    // Operand payload is qualified by s1_valid_reg, so it carries no reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_a_reg    <= bus.in_a;
            s1_b_lo_reg <= bus.in_b[SHIFT_WIDTH-1:0];
            s1_oor_reg  <= |bus.in_b[WIDTH-1:SHIFT_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_y_reg     <= '0;
            out_oor_reg   <= 1'b0;
            oor_cnt_reg   <= '0;
        end else begin
            s1_valid_reg <= in_fire | (s1_valid_reg & ~s2_load);

            if (s2_load) begin
                out_y_reg     <= y_next;
                out_oor_reg   <= s1_oor_reg;
                out_valid_reg <= 1'b1;
            end else if (out_fire) begin
                out_valid_reg <= 1'b0;
            end

            if (out_fire && out_oor_reg && (oor_cnt_reg != CNT_MAX)) begin
                oor_cnt_reg <= oor_cnt_reg + CNT_ONE;
            end
        end
    end
endmodule
